// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan decoder: segment patterns (index 0 = a),
// blank code and FSM state encoding.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    HELD
  } state_e;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  // Literals are written segment a first, matching the [0:6] bus declaration.
  localparam logic [0:6] SEG_0     = 7'b0000001;
  localparam logic [0:6] SEG_1     = 7'b1001111;
  localparam logic [0:6] SEG_2     = 7'b0010010;
  localparam logic [0:6] SEG_3     = 7'b0000110;
  localparam logic [0:6] SEG_4     = 7'b1001100;
  localparam logic [0:6] SEG_5     = 7'b0100100;
  localparam logic [0:6] SEG_6     = 7'b0100000;
  localparam logic [0:6] SEG_7     = 7'b0001111;
  localparam logic [0:6] SEG_8     = 7'b0000000;
  localparam logic [0:6] SEG_9     = 7'b0000100;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Scanned display bus plus the recovered-digit outputs of the decoder.
interface seg7_scan_if;
  logic [0:6]  seg_n;
  logic [3:0]  an_n;
  logic [15:0] bcd_digits;
  logic [3:0]  digit_valid;
  logic [3:0]  pattern_err;
  logic        frame_done;

  modport master (
    output seg_n, an_n,
    input  bcd_digits, digit_valid, pattern_err, frame_done
  );

  modport slave (
    input  seg_n, an_n,
    output bcd_digits, digit_valid, pattern_err, frame_done
  );
endinterface

// File: rtl/seg7_pattern_lut.sv
// Combinational map from an active-low segment pattern to its BCD code.
module seg7_pattern_lut
  import seg7_pkg::*;
(
  input  logic [0:6] pattern,
  output logic [3:0] code,
  output logic       recognised
);

  always_comb begin
    code       = '0;
    recognised = 1'b1;
    case (pattern)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: code = BLANK_CODE;
      default:   recognised = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receiver for a multiplexed 4-digit active-low 7-segment bus: debounces each
// scanned (anode, pattern) sample and recovers per-digit BCD with ageing.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input logic       clk,
  input logic       rst,
  seg7_scan_if.slave bus
);

  localparam logic [3:0]  STABLE_CNT  = 4'(STABLE_CYCLES);
  localparam logic [15:0] TIMEOUT_AGE = 16'(TIMEOUT_CYCLES);

  state_e            state_q, state_d;
  logic [3:0]        count_q, count_d;
  logic [3:0]        an_lat_q, an_lat_d;
  logic [0:6]        seg_lat_q, seg_lat_d;
  logic [15:0]       bcd_q, bcd_d;
  logic [3:0]        valid_q, valid_d;
  logic [3:0]        err_q, err_d;
  logic [3:0]        mask_q, mask_d;
  logic              frame_q, frame_d;
  logic [3:0][15:0]  age_q, age_d;

  logic       legal, same, capture;
  logic [1:0] idx;
  logic [3:0] lut_code;
  logic       lut_ok;

  seg7_pattern_lut u_lut (
    .pattern    (bus.seg_n),
    .code       (lut_code),
    .recognised (lut_ok)
  );

  assign legal = $onehot(~bus.an_n);
  assign same  = (bus.an_n == an_lat_q) && (bus.seg_n == seg_lat_q);

  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!bus.an_n[i]) idx = 2'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    an_lat_d  = an_lat_q;
    seg_lat_d = seg_lat_q;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        if (legal) begin
          state_d   = TRACK;
          count_d   = 4'd1;
          an_lat_d  = bus.an_n;
          seg_lat_d = bus.seg_n;
        end
      end
      TRACK: begin
        if (!legal) begin
          state_d = IDLE;
          count_d = '0;
        end else if (same) begin
          count_d = count_q + 4'd1;
        end else begin
          count_d   = 4'd1;
          an_lat_d  = bus.an_n;
          seg_lat_d = bus.seg_n;
        end
      end
      HELD: begin
        if (!legal) begin
          state_d = IDLE;
          count_d = '0;
        end else if (!same) begin
          state_d   = TRACK;
          count_d   = 4'd1;
          an_lat_d  = bus.an_n;
          seg_lat_d = bus.seg_n;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
    // Threshold is tested on the next count so STABLE_CYCLES=1 captures on the first sample.
    if (state_d == TRACK && count_d == STABLE_CNT) begin
      capture = 1'b1;
      state_d = HELD;
    end
  end

  always_comb begin
    bcd_d   = bcd_q;
    valid_d = valid_q;
    err_d   = err_q;
    mask_d  = mask_q;
    frame_d = 1'b0;
    age_d   = age_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (age_q[i] != 16'hFFFF) age_d[i] = age_q[i] + 16'd1;
      if (age_d[i] == TIMEOUT_AGE) valid_d[i] = 1'b0;
    end
    // Applied after ageing so a capture overrides a same-cycle timeout.
    if (capture) begin
      if (lut_ok) begin
        bcd_d[4*idx +: 4] = lut_code;
        valid_d[idx]      = 1'b1;
        err_d[idx]        = 1'b0;
        age_d[idx]        = '0;
        mask_d[idx]       = 1'b1;
      end else begin
        err_d[idx] = 1'b1;
      end
    end
    if (mask_d == 4'b1111) begin
      frame_d = 1'b1;
      mask_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      an_lat_q  <= '1;
      seg_lat_q <= '1;
      bcd_q     <= '0;
      valid_q   <= '0;
      err_q     <= '0;
      mask_q    <= '0;
      frame_q   <= 1'b0;
      age_q     <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      an_lat_q  <= an_lat_d;
      seg_lat_q <= seg_lat_d;
      bcd_q     <= bcd_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      mask_q    <= mask_d;
      frame_q   <= frame_d;
      age_q     <= age_d;
    end
  end

  assign bus.bcd_digits  = bcd_q;
  assign bus.digit_valid = valid_q;
  assign bus.pattern_err = err_q;
  assign bus.frame_done  = frame_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: vector table on the default instance plus
// hand sequences for reset abort, restart, timeout and single-sample capture.
module tb_seg7_scan_decoder;
  import seg7_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  seg7_scan_if bus_m ();
  seg7_scan_if bus_t ();
  seg7_scan_if bus_s ();

  seg7_scan_decoder #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(65535)) dut (
    .clk (clk), .rst (rst), .bus (bus_m)
  );
  seg7_scan_decoder #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(8)) dut_t (
    .clk (clk), .rst (rst), .bus (bus_t)
  );
  seg7_scan_decoder #(.STABLE_CYCLES(1), .TIMEOUT_CYCLES(65535)) dut_s (
    .clk (clk), .rst (rst), .bus (bus_s)
  );

  typedef struct {
    logic [3:0]  an;
    logic [0:6]  seg;
    int unsigned cycles;
    logic [15:0] bcd;
    logic [3:0]  valid;
    logic [3:0]  err;
    logic        fd;
  } vec_t;

  vec_t vecs [14];

  task automatic set_in(input logic [3:0] an, input logic [0:6] seg);
    bus_m.an_n = an; bus_m.seg_n = seg;
    bus_t.an_n = an; bus_t.seg_n = seg;
    bus_s.an_n = an; bus_s.seg_n = seg;
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    set_in(4'b1111, 7'b1111111);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{4'b1110, 7'b0010010, 4, 16'h0002, 4'b0001, 4'b0000, 1'b0};
    vecs[1]  = '{4'b1101, 7'b0001111, 4, 16'h0072, 4'b0011, 4'b0000, 1'b0};
    vecs[2]  = '{4'b1011, 7'b0000100, 4, 16'h0972, 4'b0111, 4'b0000, 1'b0};
    vecs[3]  = '{4'b0111, 7'b1111111, 4, 16'hF972, 4'b1111, 4'b0000, 1'b1};
    vecs[4]  = '{4'b0111, 7'b1111111, 1, 16'hF972, 4'b1111, 4'b0000, 1'b0};
    vecs[5]  = '{4'b1101, 7'b0101010, 4, 16'hF972, 4'b1111, 4'b0010, 1'b0};
    vecs[6]  = '{4'b1101, 7'b0000110, 4, 16'hF932, 4'b1111, 4'b0000, 1'b0};
    vecs[7]  = '{4'b1110, 7'b0000000, 3, 16'hF932, 4'b1111, 4'b0000, 1'b0};
    vecs[8]  = '{4'b1110, 7'b0000000, 1, 16'hF938, 4'b1111, 4'b0000, 1'b0};
    vecs[9]  = '{4'b1011, 7'b1001100, 4, 16'hF438, 4'b1111, 4'b0000, 1'b0};
    vecs[10] = '{4'b0111, 7'b0100000, 4, 16'h6438, 4'b1111, 4'b0000, 1'b1};
    vecs[11] = '{4'b1110, 7'b1001111, 4, 16'h6431, 4'b1111, 4'b0000, 1'b0};
    vecs[12] = '{4'b1101, 7'b0100100, 4, 16'h6451, 4'b1111, 4'b0000, 1'b0};
    vecs[13] = '{4'b1100, 7'b0000001, 4, 16'h6451, 4'b1111, 4'b0000, 1'b0};

    do_reset();
    chk("reset_bcd",   32'(bus_m.bcd_digits),  32'h0);
    chk("reset_valid", 32'(bus_m.digit_valid), 32'h0);
    chk("reset_err",   32'(bus_m.pattern_err), 32'h0);
    chk("reset_frame", 32'(bus_m.frame_done),  32'h0);

    // Single digit-0 capture of pattern "0"
    set_in(4'b1110, 7'b0000001);
    tick(3);
    chk("d0_pre_valid", 32'(bus_m.digit_valid), 32'h0);
    tick(1);
    chk("d0_bcd",   32'(bus_m.bcd_digits),  32'h0);
    chk("d0_valid", 32'(bus_m.digit_valid), 32'h1);
    chk("d0_frame", 32'(bus_m.frame_done),  32'h0);

    do_reset();
    for (int i = 0; i < 14; i++) begin
      set_in(vecs[i].an, vecs[i].seg);
      tick(vecs[i].cycles);
      chk($sformatf("vec%0d_bcd", i),   32'(bus_m.bcd_digits),  32'(vecs[i].bcd));
      chk($sformatf("vec%0d_valid", i), 32'(bus_m.digit_valid), 32'(vecs[i].valid));
      chk($sformatf("vec%0d_err", i),   32'(bus_m.pattern_err), 32'(vecs[i].err));
      chk($sformatf("vec%0d_frame", i), 32'(bus_m.frame_done),  32'(vecs[i].fd));
    end

    // Reset after 3 of 4 stable samples aborts the capture
    set_in(4'b1011, 7'b0000001);
    tick(3);
    rst = 1'b1;
    tick(1);
    chk("rstabort_bcd",   32'(bus_m.bcd_digits),  32'h0);
    chk("rstabort_valid", 32'(bus_m.digit_valid), 32'h0);
    chk("rstabort_err",   32'(bus_m.pattern_err), 32'h0);
    chk("rstabort_frame", 32'(bus_m.frame_done),  32'h0);
    chk("rstabort_state", 32'(dut.state_q),       32'(IDLE));
    rst = 1'b0;
    tick(3);
    chk("rstabort_restart_pre", 32'(bus_m.digit_valid), 32'h0);
    tick(1);
    chk("rstabort_restart", 32'(bus_m.digit_valid), 32'h4);

    // Illegal anode after 3 samples returns to IDLE; full count needed again
    do_reset();
    set_in(4'b1011, 7'b0010010);
    tick(3);
    set_in(4'b1001, 7'b0010010);
    tick(1);
    chk("illegal_state", 32'(dut.state_q),       32'(IDLE));
    chk("illegal_valid", 32'(bus_m.digit_valid), 32'h0);
    set_in(4'b1011, 7'b0010010);
    tick(3);
    chk("illegal_recount_pre", 32'(bus_m.digit_valid), 32'h0);
    tick(1);
    chk("illegal_recount_valid", 32'(bus_m.digit_valid), 32'h4);
    chk("illegal_recount_bcd",   32'(bus_m.bcd_digits),  32'h0200);

    // One differing pattern mid-hold restarts the count
    do_reset();
    set_in(4'b1110, 7'b0010010);
    tick(2);
    set_in(4'b1110, 7'b0000110);
    tick(1);
    set_in(4'b1110, 7'b0010010);
    tick(3);
    chk("glitch_pre_valid", 32'(bus_m.digit_valid), 32'h0);
    tick(1);
    chk("glitch_bcd", 32'(bus_m.bcd_digits), 32'h0002);

    // Timeout instance: valid clears exactly 8 cycles after capture
    do_reset();
    set_in(4'b1110, 7'b0000001);
    tick(4);
    chk("to_capture", 32'(bus_t.digit_valid), 32'h1);
    set_in(4'b1111, 7'b0000001);
    tick(7);
    chk("to_age7", 32'(bus_t.digit_valid), 32'h1);
    tick(1);
    chk("to_age8", 32'(bus_t.digit_valid), 32'h0);

    // Capture landing on the timeout edge keeps valid set
    do_reset();
    set_in(4'b1110, 7'b0000001);
    tick(4);
    set_in(4'b1111, 7'b0000001);
    tick(4);
    set_in(4'b1110, 7'b0000001);
    tick(3);
    chk("to_race_pre", 32'(bus_t.digit_valid), 32'h1);
    tick(1);
    chk("to_race_win", 32'(bus_t.digit_valid), 32'h1);
    tick(7);
    chk("to_race_age7", 32'(bus_t.digit_valid), 32'h1);
    tick(1);
    chk("to_race_age8", 32'(bus_t.digit_valid), 32'h0);

    // STABLE_CYCLES=1 captures on the first legal sample
    do_reset();
    set_in(4'b1101, 7'b0000100);
    tick(1);
    chk("s1_bcd",   32'(bus_s.bcd_digits),  32'h0090);
    chk("s1_valid", 32'(bus_s.digit_valid), 32'h2);
    set_in(4'b1101, 7'b1001100);
    tick(1);
    chk("s1_bcd2", 32'(bus_s.bcd_digits), 32'h0040);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
